// File: rtl/e_scale_sched_pkg.sv
// Shared definitions for the e_scale_sched scheduler: FSM states, rank width
// and default pipeline/FIFO sizing.
package e_scale_sched_pkg;

  localparam int unsigned RANK_W        = 6;
  localparam int unsigned PIPE_LAT_DEF  = 3;
  localparam int unsigned RES_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/e_scale_sched_track.sv
// Issue tracker for the scaling pipeline: a valid bit per pipeline stage.
// The last stage drives the result-FIFO push; inflight is the number of
// batches issued but not yet pushed.
module e_scale_sched_track #(
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned IF_W     = $clog2(PIPE_LAT + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  output logic            push_o,
  output logic [IF_W-1:0] inflight_o
);

  logic [PIPE_LAT-1:0] vld_q;
  logic [PIPE_LAT-1:0] vld_d;

  // Shift a new issue into stage 0 every cycle.
  always_comb begin
    vld_d = (vld_q << 1) | PIPE_LAT'(en_i);
  end

  // Valid pipeline register; reset discards anything still in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign push_o = vld_q[PIPE_LAT-1];

  // Popcount of the valid stages.
  always_comb begin
    inflight_o = '0;
    for (int unsigned i = 0; i < PIPE_LAT; i++) begin
      inflight_o = inflight_o + IF_W'(vld_q[i]);
    end
  end

endmodule

// File: rtl/e_scale_sched.sv
// Credit-based issue scheduler for the e-scale datapath. Accepts a job
// descriptor, issues cfg_batches operand batches while the result FIFO has
// room, and tracks results through to the last pop.
// Optional feature: define E_SCALE_SCHED_PERF_EN to add perf_cycles and
// perf_stall counters.
module e_scale_sched
  import e_scale_sched_pkg::*;
#(
  parameter int unsigned DSP_NUM   = 192,
  parameter int unsigned PIPE_LAT  = PIPE_LAT_DEF,
  parameter int unsigned RES_DEPTH = RES_DEPTH_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_batches,
  input  logic [RANK_W-1:0] cfg_rank,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              es_en,
  output logic [RANK_W-1:0] es_scale_rank,
  output logic              res_push,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef E_SCALE_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned OCC_W = $clog2(RES_DEPTH + 1);
  localparam int unsigned IF_W  = $clog2(PIPE_LAT + 1);

  // Reject degenerate configurations at elaboration.
  if (DSP_NUM == 0 || PIPE_LAT == 0 || RES_DEPTH == 0) begin : g_bad_cfg
    $error("e_scale_sched: DSP_NUM, PIPE_LAT and RES_DEPTH must be non-zero");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  batches_q, batches_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  popped_q, popped_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [RANK_W-1:0] rank_q, rank_d;
  logic [IF_W-1:0]   inflight;
  logic              credit_ok;
  logic              accept;
  logic              pop;

  e_scale_sched_track #(
    .PIPE_LAT (PIPE_LAT),
    .IF_W     (IF_W)
  ) u_track (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (es_en),
    .push_o     (res_push),
    .inflight_o (inflight)
  );

  // Handshake and status decode from registered state and counters.
  assign credit_ok     = (32'(occ_q) + 32'(inflight)) < RES_DEPTH;
  assign in_ready      = (state_q == ST_RUN) && (issued_q < batches_q) && credit_ok;
  assign es_en         = in_valid && in_ready;
  assign out_valid     = (occ_q != '0);
  assign pop           = out_valid && out_ready;
  assign out_last      = out_valid && (popped_q == batches_q - CNT_W'(1));
  assign cfg_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign accept        = (state_q == ST_IDLE) && cfg_valid;
  assign es_scale_rank = rank_q;

  // Next-state and counter update logic.
  always_comb begin
    state_d   = state_q;
    batches_d = batches_q;
    issued_d  = issued_q;
    popped_d  = popped_q;
    occ_d     = occ_q;
    rank_d    = rank_q;

    if (es_en) issued_d = issued_q + CNT_W'(1);
    if (pop)   popped_d = popped_q + CNT_W'(1);

    if (res_push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!res_push && pop) begin
      occ_d = occ_q - OCC_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          batches_d = cfg_batches;
          rank_d    = cfg_rank;
          issued_d  = '0;
          popped_d  = '0;
          state_d   = (cfg_batches == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issued_q == batches_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((inflight == '0) && (popped_q == batches_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      batches_q <= '0;
      issued_q  <= '0;
      popped_q  <= '0;
      occ_q     <= '0;
      rank_q    <= '0;
    end else begin
      state_q   <= state_d;
      batches_q <= batches_d;
      issued_q  <= issued_d;
      popped_q  <= popped_d;
      occ_q     <= occ_d;
      rank_q    <= rank_d;
    end
  end

`ifdef E_SCALE_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Active and stall cycle counting, restarted on each accepted job.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (accept) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (state_q == ST_RUN || state_q == ST_DRAIN) perf_cycles_d = perf_cycles_q + 32'd1;
      if (state_q == ST_RUN && in_valid && !in_ready) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_e_scale_sched.sv
// Directed bench for e_scale_sched: a per-cycle vector table for a basic job
// and an empty job, plus sequences for backpressure, simultaneous push/pop,
// mid-job reset and a full-range batch count on a narrow-counter instance.
module tb_e_scale_sched;

  localparam int MAXC = 200;
  localparam int NVEC = 15;

  logic        CLK, RST;
  logic        cfg_valid, cfg_ready, in_valid, in_ready, es_en, res_push;
  logic        out_valid, out_ready, out_last, busy, done;
  logic [15:0] cfg_batches;
  logic [5:0]  cfg_rank, es_scale_rank;

  logic        s_cfg_valid, s_cfg_ready, s_in_valid, s_in_ready, s_es_en, s_res_push;
  logic        s_out_valid, s_out_ready, s_out_last, s_busy, s_done;
  logic [2:0]  s_cfg_batches;
  logic [5:0]  s_cfg_rank, s_es_scale_rank;
`ifdef E_SCALE_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stall, s_perf_cycles, s_perf_stall;
`endif

  e_scale_sched u_dut (
    .CLK(CLK), .RST(RST),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_batches(cfg_batches), .cfg_rank(cfg_rank),
    .in_valid(in_valid), .in_ready(in_ready),
    .es_en(es_en), .es_scale_rank(es_scale_rank), .res_push(res_push),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
`ifdef E_SCALE_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  e_scale_sched #(.CNT_W(3)) u_dut_small (
    .CLK(CLK), .RST(RST),
    .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready),
    .cfg_batches(s_cfg_batches), .cfg_rank(s_cfg_rank),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .es_en(s_es_en), .es_scale_rank(s_es_scale_rank), .res_push(s_res_push),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_last(s_out_last),
    .busy(s_busy), .done(s_done)
`ifdef E_SCALE_SCHED_PERF_EN
    , .perf_cycles(s_perf_cycles), .perf_stall(s_perf_stall)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // {in_ready, cfg_ready, busy, done, es_en, res_push, out_valid, out_last}
  function automatic logic [7:0] obs();
    return {in_ready, cfg_ready, busy, done, es_en, res_push, out_valid, out_last};
  endfunction

  typedef struct packed {
    logic        cfg_valid;
    logic [15:0] batches;
    logic [5:0]  rank;
    logic [6:0]  exp_o;     // {cfg_ready, busy, done, es_en, res_push, out_valid, out_last}
    logic [5:0]  exp_rank;
  } vec_t;

  function automatic vec_t mk(input logic cv, input int nb, input logic [5:0] rk,
                              input logic [6:0] eo, input logic [5:0] er);
    vec_t v;
    v.cfg_valid = cv;
    v.batches   = 16'(nb);
    v.rank      = rk;
    v.exp_o     = eo;
    v.exp_rank  = er;
    return v;
  endfunction

  logic [7:0] log_o [MAXC];

  // One job on the main instance; out_ready low in [or_lo_from, or_lo_to) except at or_pulse.
  task automatic run_job(input int nb, input logic [5:0] rk,
                         input int iv_lo_from, input int iv_lo_to,
                         input int or_lo_from, input int or_lo_to, input int or_pulse,
                         output int issues, output int pushes, output int pops,
                         output int n_last, output int last_idx, output int done_k);
    issues = 0; pushes = 0; pops = 0; n_last = 0; last_idx = -1; done_k = -1;
    for (int k = 0; k < MAXC; k++) log_o[k] = '0;
    for (int k = 0; k < MAXC; k++) begin
      @(negedge CLK);
      cfg_valid   = (k == 0);
      cfg_batches = 16'(nb);
      cfg_rank    = rk;
      in_valid    = !(k >= iv_lo_from && k < iv_lo_to);
      out_ready   = !(k >= or_lo_from && k < or_lo_to) || (k == or_pulse);
      #1;
      log_o[k] = obs();
      if (es_en) issues++;
      if (res_push) pushes++;
      if (out_valid && out_ready) begin
        pops++;
        if (out_last) begin
          n_last++;
          last_idx = pops;
        end
      end
      if (done) begin
        done_k = k;
        break;
      end
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  vec_t tbl [NVEC];
  int   iss, psh, pop_n, nl, lidx, dk, cnt;
  logic [7:0] o;

  initial begin
    RST = 1'b0; cfg_valid = 1'b0; cfg_batches = '0; cfg_rank = '0; in_valid = 1'b0; out_ready = 1'b0;
    s_cfg_valid = 1'b0; s_cfg_batches = '0; s_cfg_rank = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    o = obs();
    check("reset_outs", {24'd0, o[7], o[5:0]}, 32'd0);
    check("reset_rank", 32'(es_scale_rank), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("reset_cfg_ready", 32'(cfg_ready), 32'd1);

    // 4-batch job at rank -2 with stray descriptors in RUN/DRAIN, then an empty job at rank 5.
    tbl[0]  = mk(1'b1, 4, 6'h3E, 7'b1000000, 6'h00);
    tbl[1]  = mk(1'b0, 4, 6'h3E, 7'b0101000, 6'h3E);
    tbl[2]  = mk(1'b0, 4, 6'h3E, 7'b0101000, 6'h3E);
    tbl[3]  = mk(1'b1, 7, 6'h01, 7'b0101000, 6'h3E);
    tbl[4]  = mk(1'b0, 4, 6'h3E, 7'b0101100, 6'h3E);
    tbl[5]  = mk(1'b0, 4, 6'h3E, 7'b0100110, 6'h3E);
    tbl[6]  = mk(1'b0, 4, 6'h3E, 7'b0100110, 6'h3E);
    tbl[7]  = mk(1'b1, 7, 6'h01, 7'b0100110, 6'h3E);
    tbl[8]  = mk(1'b0, 4, 6'h3E, 7'b0100011, 6'h3E);
    tbl[9]  = mk(1'b0, 4, 6'h3E, 7'b0100000, 6'h3E);
    tbl[10] = mk(1'b0, 4, 6'h3E, 7'b0110000, 6'h3E);
    tbl[11] = mk(1'b0, 4, 6'h3E, 7'b1000000, 6'h3E);
    tbl[12] = mk(1'b1, 0, 6'h05, 7'b1000000, 6'h3E);
    tbl[13] = mk(1'b0, 0, 6'h05, 7'b0110000, 6'h05);
    tbl[14] = mk(1'b0, 0, 6'h05, 7'b1000000, 6'h05);
    for (int i = 0; i < NVEC; i++) begin
      @(negedge CLK);
      cfg_valid   = tbl[i].cfg_valid;
      cfg_batches = tbl[i].batches;
      cfg_rank    = tbl[i].rank;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      #1;
      o = obs();
      check($sformatf("vec%0d_outs", i), 32'(o[6:0]), 32'(tbl[i].exp_o));
      check($sformatf("vec%0d_rank", i), 32'(es_scale_rank), 32'(tbl[i].exp_rank));
    end
    cfg_valid = 1'b0; in_valid = 1'b0;

    // Backpressure: 20 batches with out_ready low for the first 20 cycles.
    run_job(20, 6'h07, 0, 0, 0, 20, -1, iss, psh, pop_n, nl, lidx, dk);
    cnt = 0;
    for (int k = 0; k < 20; k++) cnt += int'(log_o[k][3]);
    check("bp_issues_while_full", 32'(cnt), 32'd8);
    check("bp_in_ready_blocked", 32'(log_o[19][7]), 32'd0);
    check("bp_issues_total", 32'(iss), 32'd20);
    check("bp_pushes_total", 32'(psh), 32'd20);
    check("bp_pops_total", 32'(pop_n), 32'd20);
    check("bp_last_count", 32'(nl), 32'd1);
    check("bp_last_index", 32'(lidx), 32'd20);
    check("bp_done_seen", 32'(dk >= 0), 32'd1);

    // Push and pop together while three results are held.
    run_job(6, 6'h0A, 0, 0, 0, 10, 7, iss, psh, pop_n, nl, lidx, dk);
    check("pp_push_and_pop_k7", 32'(log_o[7][2:1]), 32'd3);
    check("pp_out_valid_k8", 32'(log_o[8][1]), 32'd1);
    check("pp_pops_total", 32'(pop_n), 32'd6);
    check("pp_last_index", 32'(lidx), 32'd6);
    check("pp_done_cycle", 32'(dk), 32'd16);

    // in_valid low for two RUN cycles is idle time, not stall.
    run_job(4, 6'h11, 1, 3, 0, 0, -1, iss, psh, pop_n, nl, lidx, dk);
    check("gap_issues", 32'(iss), 32'd4);
    check("gap_done_cycle", 32'(dk), 32'd12);
`ifdef E_SCALE_SCHED_PERF_EN
    check("perf_cycles", perf_cycles, 32'd11);
    check("perf_stall", perf_stall, 32'd0);
`endif

    // Reset on the second issue of a 10-batch job.
    @(negedge CLK);
    cfg_valid = 1'b1; cfg_batches = 16'd10; cfg_rank = 6'h15; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge CLK);
    cfg_valid = 1'b0;
    #1 check("rst_first_issue", 32'(es_en), 32'd1);
    @(negedge CLK);
    #1 check("rst_second_issue", 32'(es_en), 32'd1);
    #1 RST = 1'b1;
    #1;
    o = obs();
    check("rst_async_outs", {24'd0, o[7], o[5:0]}, 32'd0);
    check("rst_async_rank", 32'(es_scale_rank), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0; in_valid = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge CLK);
      #1 cnt += int'(res_push);
    end
    check("rst_no_late_push", 32'(cnt), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    run_job(2, 6'h02, 0, 0, 0, 0, -1, iss, psh, pop_n, nl, lidx, dk);
    check("rst_job_issues", 32'(iss), 32'd2);
    check("rst_job_pops", 32'(pop_n), 32'd2);
    check("rst_job_last_index", 32'(lidx), 32'd2);
    check("rst_job_done_cycle", 32'(dk), 32'd8);

    // Full-range batch count (2^3-1) on the narrow-counter instance.
    iss = 0; psh = 0; pop_n = 0; lidx = -1; dk = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      s_cfg_valid = (k == 0); s_cfg_batches = 3'd7; s_cfg_rank = 6'h20;
      s_in_valid = 1'b1; s_out_ready = 1'b1;
      #1;
      if (k == 0) check("small_cfg_ready", 32'(s_cfg_ready), 32'd1);
      if (k == 8) check("small_in_ready_end", 32'(s_in_ready), 32'd0);
      if (s_es_en) iss++;
      if (s_res_push) psh++;
      if (s_out_valid && s_out_ready) begin
        pop_n++;
        if (s_out_last) lidx = pop_n;
      end
      if (s_done) begin
        dk = k;
        check("small_busy_in_done", 32'(s_busy), 32'd1);
        break;
      end
    end
    s_cfg_valid = 1'b0; s_in_valid = 1'b0;
    check("small_issues", 32'(iss), 32'd7);
    check("small_pushes", 32'(psh), 32'd7);
    check("small_pops", 32'(pop_n), 32'd7);
    check("small_last_index", 32'(lidx), 32'd7);
    check("small_done_cycle", 32'(dk), 32'd13);
    check("small_rank", 32'(s_es_scale_rank), 32'h20);
`ifdef E_SCALE_SCHED_PERF_EN
    check("small_perf_cycles", s_perf_cycles, 32'd12);
    check("small_perf_stall", s_perf_stall, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
